// File: rtl/result_display_ctrl.sv
// Result viewer sequencer: debounced next/prev stepping, memory fetch, double-dabble
// conversion and 4-digit multiplexed seven-segment drive. Define RESULT_DISPLAY_LZB_EN to blank leading zeros.
module result_display_ctrl #(
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 16,
    parameter int DEBOUNCE_CYC = 650000,
    parameter int SCAN_CYC     = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W-1:0] cur_index,
    output logic              busy,
    output logic [3:0]        an_n,
    output logic [6:0]        seg_n
);

    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    typedef enum logic [1:0] {ST_SHOW, ST_FETCH, ST_WAIT, ST_CONV} state_e;

    state_e              state_q, state_d;
    logic                boot_q, boot_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [19:0]         bcd_q, bcd_d, bcd_adj;
    logic [3:0]          iter_q, iter_d;
    logic [15:0]         digits_q, digits_d;
    logic                ovf_q, ovf_d;
    logic                show_valid_q, show_valid_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [3:0]          an_n_q, an_n_d;
    logic [6:0]          seg_n_q, seg_n_d;

    // Index 0 is next, index 1 is prev.
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [DB_W-1:0]     db_cnt_q [2];
    logic [DB_W-1:0]     db_cnt_d [2];
    logic [1:0]          pulse;

    logic [3:0]          sel_digit;
    logic                sel_blank;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        sync1_d    = {btn_prev, btn_next};
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int unsigned i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        pulse = deb_q & ~deb_prev_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SHOW:  if (boot_q || (pulse == 2'b01) || (pulse == 2'b10)) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_CONV;
            ST_CONV:  if (iter_q == 4'(DATA_W - 1)) state_d = ST_SHOW;
            default:  state_d = ST_SHOW;
        endcase
    end

    always_comb begin
        boot_d       = boot_q;
        index_d      = index_q;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        iter_d       = iter_q;
        digits_d     = digits_q;
        ovf_d        = ovf_q;
        show_valid_d = show_valid_q;
        bcd_adj      = bcd_q;
        for (int unsigned n = 0; n < 5; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
        case (state_q)
            ST_SHOW: begin
                if (boot_q) begin
                    boot_d = 1'b0;
                end else if (pulse == 2'b01) begin
                    index_d = (index_q == ADDR_W'(DEPTH - 1)) ? '0 : index_q + 1'b1;
                end else if (pulse == 2'b10) begin
                    index_d = (index_q == '0) ? ADDR_W'(DEPTH - 1) : index_q - 1'b1;
                end
            end
            ST_WAIT: begin
                shift_d = mem_rd_data;
                bcd_d   = '0;
                iter_d  = '0;
            end
            ST_CONV: begin
                {bcd_d, shift_d} = {bcd_adj[18:0], shift_q, 1'b0};
                iter_d           = iter_q + 1'b1;
                // Digits latch from the final shift so the display switches on the same edge.
                if (iter_q == 4'(DATA_W - 1)) begin
                    digits_d     = bcd_d[15:0];
                    ovf_d        = (bcd_d[19:16] != 4'd0);
                    show_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_rd_en = (state_q == ST_FETCH);
        busy      = (state_q != ST_SHOW);
        mem_addr  = index_q;
        cur_index = index_q;
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        ptr_d      = ptr_q;
        if (scan_cnt_q == SCAN_W'(SCAN_CYC - 1)) begin
            scan_cnt_d = '0;
            ptr_d      = ptr_q + 2'd1;
        end
        sel_blank = 1'b0;
        case (ptr_d)
            2'd0:    sel_digit = digits_d[15:12];
            2'd1:    sel_digit = digits_d[11:8];
            2'd2:    sel_digit = digits_d[7:4];
            default: sel_digit = digits_d[3:0];
        endcase
`ifdef RESULT_DISPLAY_LZB_EN
        case (ptr_d)
            2'd0:    sel_blank = (digits_d[15:12] == 4'd0);
            2'd1:    sel_blank = (digits_d[15:8] == 8'd0);
            2'd2:    sel_blank = (digits_d[15:4] == 12'd0);
            default: sel_blank = 1'b0;
        endcase
`endif
        an_n_d  = 4'b1111;
        seg_n_d = 7'b1111111;
        if (show_valid_d) begin
            an_n_d = ~(4'b1000 >> ptr_d);
            if (ovf_d)           seg_n_d = 7'b0111111;
            else if (!sel_blank) seg_n_d = seg_code(sel_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SHOW;
            boot_q       <= 1'b1;
            index_q      <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            digits_q     <= '0;
            ovf_q        <= 1'b0;
            show_valid_q <= 1'b0;
            scan_cnt_q   <= '0;
            ptr_q        <= '0;
            an_n_q       <= 4'b1111;
            seg_n_q      <= 7'b1111111;
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            db_cnt_q[0]  <= '0;
            db_cnt_q[1]  <= '0;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            index_q      <= index_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            iter_q       <= iter_d;
            digits_q     <= digits_d;
            ovf_q        <= ovf_d;
            show_valid_q <= show_valid_d;
            scan_cnt_q   <= scan_cnt_d;
            ptr_q        <= ptr_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            db_cnt_q[0]  <= db_cnt_d[0];
            db_cnt_q[1]  <= db_cnt_d[1];
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Sequencer for the 4-digit seven-segment result viewer.
- Debounces "next" and "prev" buttons and walks a read index through the CPU result memory, issuing one synchronous read per step.
- Converts the 16-bit word to decimal with an iterative double-dabble engine and time-multiplexes the four digits onto shared segment lines.
- Sits between the result memory (synchronous read, 1-cycle latency) and the board anode/segment pins.

Parameters:
- DEPTH, 32, number of result words; index wraps within 0..DEPTH-1
- ADDR_W, 5, width of mem_addr and cur_index
- DATA_W, 16, result word width; fixed at 16 for the converter
- DEBOUNCE_CYC, 650000, cycles a synchronized button level must stay stable before it is accepted
- SCAN_CYC, 500000, cycles each digit is driven before the scan advances

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, synchronous active-low reset
- btn_next, input, 1, raw asynchronous button, step forward
- btn_prev, input, 1, raw asynchronous button, step backward
- mem_addr, output, ADDR_W, read address to the result memory
- mem_rd_en, output, 1, read strobe; data is valid on mem_rd_data the cycle after
- mem_rd_data, input, DATA_W, read data from the result memory
- cur_index, output, ADDR_W, index currently displayed
- busy, output, 1, high while a fetch or conversion is in progress
- an_n, output, 4, active-low digit enables; bit 3 is the thousands digit
- seg_n, output, 7, active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: an_n=4'b1111, seg_n=7'b1111111, mem_addr=0, mem_rd_en=0, cur_index=0, busy=0.
  - Internals: debounced levels 0, scan counters 0, show_valid=0.
  - State: FETCH is entered on the first edge after reset is released, so entry 0 loads automatically.
- Button path:
  - 2-flop synchronizer, then a stability counter.
  - Debounced level updates only after the synchronized level has differed from it for DEBOUNCE_CYC consecutive cycles.
  - Rising edge of the debounced level produces a 1-cycle pulse. No pulse on release.
- FSM states: SHOW, FETCH, WAIT, CONV.
  - SHOW, next pulse only: index = (index==DEPTH-1) ? 0 : index+1, then go to FETCH.
  - SHOW, prev pulse only: index = (index==0) ? DEPTH-1 : index-1, then go to FETCH.
  - SHOW, next and prev pulses in the same cycle: both are ignored and the state stays SHOW.
  - FETCH: mem_rd_en=1, mem_addr=index, busy=1; go to WAIT.
  - WAIT: mem_rd_en=0; mem_rd_data is captured at the end of this cycle into the 16-bit shift register; the 20-bit BCD register is cleared; go to CONV.
  - CONV: 16 iterations, each adding 3 to any BCD nibble >=5, then shifting left 1.
  - CONV, after the 16th iteration: latch the digit registers, set show_valid=1, clear busy, go to SHOW.
- Timing:
  - Pulse sampled at edge E0.
  - mem_rd_en is high during E0..E1.
  - Data is captured at E2.
  - Conversion runs E3..E18.
  - The new digits drive the segments from E18.
- Button pulses arriving in FETCH/WAIT/CONV are dropped.
- Digit registers are updated atomically. The display shows the previous value until E18.
- Overflow: if the ten-thousands BCD nibble is non-zero (value >9999), all four digits show a dash (seg_n=7'b0111111).
- Scan:
  - The free-running counter counts 0..SCAN_CYC-1 and then advances the digit pointer 0→1→2→3→0.
  - It runs in every state.
  - Digit pointer to an_n: 0→0111, 1→1011, 2→1101, 3→1110.
  - an_n and seg_n are registered, so they change together.
  - While show_valid=0: an_n=4'b1111.
- Segment codes, digits 0..9:
  - 1000000, 1111001, 0100100, 0110000, 0011001
  - 0010010, 0000010, 1111000, 0000000, 0010000
- Reset asserted mid-fetch or mid-conversion: returns to the reset values and restarts with entry 0. No partial digits are displayed.

Optional Feature:
- RESULT_DISPLAY_LZB_EN defined:
  - Leading zeros are blanked (seg_n=7'b1111111 for each leading zero digit).
  - The units digit is always shown, so value 0 displays as blank-blank-blank-"0", and 42 displays as blank-blank-"4"-"2".
  - The overflow dash pattern is unaffected.
- Not defined: all four digits are always shown, zero-padded.

Test Plan:
- All scenarios use DEBOUNCE_CYC=4, SCAN_CYC=3, DEPTH=32, with the memory preloaded so that mem[i]=i*311.
- Reset release → mem_rd_en pulses with addr 0; busy falls; digits read 0000; an_n cycles 0111,1011,1101,1110 every 3 cycles; an_n=1111 before the first conversion.
- btn_next held high ≥6 cycles → exactly one step: cur_index=1, mem_addr=1, digits 0311, busy high for 19 edges. A 2-cycle glitch on btn_next → no step.
- From index 0, press btn_prev → cur_index=31, digits 9641. Then press btn_next → cur_index=0.
- mem[5]=16'd12345 and step to index 5 → all digits 0111111 (dash). mem[6]=9999 → 9999.
- btn_next and btn_prev debounced-rising in the same cycle → no mem_rd_en, index unchanged. A button pulse during CONV → dropped, with only one step taken.
- rst_n low for 1 cycle during CONV → an_n=1111 immediately after, then refetch of entry 0. With RESULT_DISPLAY_LZB_EN, index 0 shows only the units digit lit as "0".
